// File: rtl/tmp_code_accum.sv
// tmp_code_accum
//   Turns the temperature-sensor sequencer's charge phases into a 1-bit
//   sigma-delta stream. It counts high-charge events over a window of
//   2^OSR_LOG2 events and offers the count as a temperature code to the
//   readout block.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   PA/PB/PC   sequencer phases. HCHARGE = PA&PB&~PC, LCHARGE = PA&PC&~PB
//   setupBias  1 = bias calibration: events are ignored and any window in
//              progress is abandoned
//   code       H-event count of the last completed window (0..N)
//   code_vld   code holds a result that has not been consumed yet
//   code_rdy   consumer accepts code when code_vld && code_rdy
//   ovf        sticky flag: a result was overwritten before it was accepted
//   ovf_clr    synchronous clear of ovf. A same-cycle overwrite wins.
//   busy       FSM is in SETTLE or ACCUM
//   state_dbg  raw FSM state, for debug and assertion binding
//
// Handshake: code/code_vld form a valid/ready source. A transfer happens on
// every cycle with code_vld && code_rdy. code_vld falls on the next cycle
// unless a new window completes in that same cycle. code_rdy has no effect
// while code_vld is low. A completing window always loads code, even when the
// previous code was never accepted; that case raises ovf.
module tmp_code_accum #(
  parameter int OSR_LOG2 = 8,
  parameter int DISCARD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PA,
  input  logic              PB,
  input  logic              PC,
  input  logic              setupBias,
  output logic [OSR_LOG2:0] code,
  output logic              code_vld,
  input  logic              code_rdy,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CW = OSR_LOG2 + 1;
  localparam int DW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  // evt_cnt never holds N. The N-th event closes the window and restarts
  // the count in the same cycle.
  localparam logic [CW-1:0] EVT_LAST  = CW'((1 << OSR_LOG2) - 1);
  localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD > 0) ? DISCARD - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Event decode. The previous-cycle phase flops reset to 1, so a phase that
  // is already high when reset releases does not count as a rising edge.
  logic hq, lq, hq_q, lq_q, h_evt, l_evt, evt;

  assign hq    = PA & PB & ~PC;
  assign lq    = PA & PC & ~PB;
  assign h_evt = hq & ~hq_q;
  assign l_evt = lq & ~lq_q;
  assign evt   = h_evt | l_evt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hq_q <= 1'b1;
      lq_q <= 1'b1;
    end else begin
      hq_q <= hq;
      lq_q <= lq;
    end
  end

  logic [DW-1:0] disc_cnt;
  logic [CW-1:0] evt_cnt, h_cnt;
  logic          disc_load, disc_inc, cnt_clear, cnt_inc, win_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    disc_load = 1'b0;
    disc_inc  = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    win_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!setupBias) begin
          state_nxt = S_SETTLE;
          disc_load = 1'b1;
        end
      end
      S_SETTLE: begin
        if (setupBias) begin
          state_nxt = S_IDLE;
        end else if (DISCARD == 0) begin
          state_nxt = S_ACCUM;
          cnt_clear = 1'b1;
        end else if (evt) begin
          if (disc_cnt == DISC_LAST) begin
            state_nxt = S_ACCUM;
            cnt_clear = 1'b1;
          end else begin
            disc_inc = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        // An abort takes priority over an event arriving in the same cycle.
        if (setupBias) begin
          state_nxt = S_IDLE;
        end else if (evt) begin
          if (evt_cnt == EVT_LAST) win_done = 1'b1;
          else                     cnt_inc  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disc_cnt <= '0;
      evt_cnt  <= '0;
      h_cnt    <= '0;
      code     <= '0;
      code_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (disc_load)     disc_cnt <= '0;
      else if (disc_inc) disc_cnt <= disc_cnt + DW'(1);

      // Windows run back-to-back. The closing event restarts both counters.
      if (cnt_clear || win_done) begin
        evt_cnt <= '0;
        h_cnt   <= '0;
      end else if (cnt_inc) begin
        evt_cnt <= evt_cnt + CW'(1);
        h_cnt   <= h_cnt + CW'(h_evt);
      end

      if (win_done) begin
        code     <= h_cnt + CW'(h_evt);
        code_vld <= 1'b1;
      end else if (code_vld && code_rdy) begin
        code_vld <= 1'b0;
      end

      if (win_done && code_vld && !code_rdy) ovf <= 1'b1;
      else if (ovf_clr)                      ovf <= 1'b0;
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_tmp_code_accum.sv
// tb_tmp_code_accum
//   Two instances share one stimulus stream. Both use OSR_LOG2=3 (N=8).
//   dut_a uses DISCARD=2 and dut_b uses DISCARD=0. A cycle-level reference
//   model (window counts kept as plain integers) is checked on every cycle.
//   Directed windows with hand-computed codes cover the corner cases.
module tb_tmp_code_accum;

  logic       clk;
  logic       reset;
  logic       PA, PB, PC, setupBias, code_rdy, ovf_clr;
  logic [3:0] code_a, code_b;
  logic       vld_a, vld_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  tmp_code_accum #(.OSR_LOG2(3), .DISCARD(2)) dut_a (
    .clk(clk), .reset(reset), .PA(PA), .PB(PB), .PC(PC), .setupBias(setupBias),
    .code(code_a), .code_vld(vld_a), .code_rdy(code_rdy), .ovf(ovf_a),
    .ovf_clr(ovf_clr), .busy(busy_a), .state_dbg(st_a)
  );

  tmp_code_accum #(.OSR_LOG2(3), .DISCARD(0)) dut_b (
    .clk(clk), .reset(reset), .PA(PA), .PB(PB), .PC(PC), .setupBias(setupBias),
    .code(code_b), .code_vld(vld_b), .code_rdy(code_rdy), .ovf(ovf_b),
    .ovf_clr(ovf_clr), .busy(busy_b), .state_dbg(st_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 = idle, 1 = discarding, 2 = accumulating
  bit m_hq_prev, m_lq_prev;
  int m_mode[2], m_disc[2], m_cnt[2], m_hc[2], m_code[2];
  bit m_vld[2], m_ovf[2];

  function automatic int disc_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  always @(posedge clk or negedge reset) begin : ref_model
    bit hq, lq, h, l, ev, done;
    int nc;
    if (!reset) begin
      m_hq_prev = 1'b1;
      m_lq_prev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_disc[i] = 0; m_cnt[i] = 0; m_hc[i] = 0;
        m_code[i] = 0; m_vld[i] = 1'b0; m_ovf[i] = 1'b0;
      end
    end else begin
      hq = PA && PB && !PC;
      lq = PA && PC && !PB;
      h  = hq && !m_hq_prev;
      l  = lq && !m_lq_prev;
      ev = h || l;
      for (int i = 0; i < 2; i++) begin
        done = 1'b0;
        nc   = 0;
        case (m_mode[i])
          0: if (!setupBias) begin m_mode[i] = 1; m_disc[i] = 0; end
          1: begin
            if (setupBias) m_mode[i] = 0;
            else if (disc_of(i) == 0) begin
              m_mode[i] = 2; m_cnt[i] = 0; m_hc[i] = 0;
            end else if (ev) begin
              m_disc[i]++;
              if (m_disc[i] == disc_of(i)) begin
                m_mode[i] = 2; m_cnt[i] = 0; m_hc[i] = 0;
              end
            end
          end
          default: begin
            if (setupBias) m_mode[i] = 0;
            else if (ev) begin
              m_cnt[i]++;
              if (h) m_hc[i]++;
              if (m_cnt[i] == 8) begin
                done = 1'b1; nc = m_hc[i]; m_cnt[i] = 0; m_hc[i] = 0;
              end
            end
          end
        endcase
        if (done && m_vld[i] && !code_rdy) m_ovf[i] = 1'b1;
        else if (ovf_clr)                  m_ovf[i] = 1'b0;
        if (done) begin
          m_code[i] = nc; m_vld[i] = 1'b1;
        end else if (m_vld[i] && code_rdy) begin
          m_vld[i] = 1'b0;
        end
      end
      m_hq_prev = hq;
      m_lq_prev = lq;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, then compare both instances against the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    chk("a_code", 32'(code_a), 32'(m_code[0]));
    chk("a_vld",  32'(vld_a),  32'(m_vld[0]));
    chk("a_ovf",  32'(ovf_a),  32'(m_ovf[0]));
    chk("a_busy", 32'(busy_a), 32'(m_mode[0] != 0));
    chk("b_code", 32'(code_b), 32'(m_code[1]));
    chk("b_vld",  32'(vld_b),  32'(m_vld[1]));
    chk("b_ovf",  32'(ovf_b),  32'(m_ovf[1]));
    chk("b_busy", 32'(busy_b), 32'(m_mode[1] != 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_phase(input bit h);
    {PA, PB, PC} = h ? 3'b110 : 3'b101;
  endtask

  task automatic set_idle();
    {PA, PB, PC} = 3'b000;
  endtask

  task automatic pulse(input bit h);
    drive_phase(h);
    repeat (3) cycle();
    set_idle();
    repeat (2) cycle();
  endtask

  typedef struct {
    logic [7:0] pat;      // event sequence, MSB first, 1 = H
    logic       rdy;
    logic [3:0] exp_code;
    logic       exp_ovf;
  } win_t;

  win_t win_tab[6];

  // Applies one 8-event window and checks dut_b on the closing event.
  task automatic run_window(input win_t w, input int idx);
    code_rdy = w.rdy;
    for (int b = 7; b >= 1; b--) pulse(w.pat[b]);
    drive_phase(w.pat[0]);
    cycle();
    chk($sformatf("win%0d_code", idx), 32'(code_b), 32'(w.exp_code));
    chk($sformatf("win%0d_vld", idx),  32'(vld_b),  32'd1);
    chk($sformatf("win%0d_ovf", idx),  32'(ovf_b),  32'(w.exp_ovf));
    repeat (2) cycle();
    set_idle();
    repeat (2) cycle();
  endtask

  logic [2:0] filt[5];

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    win_tab[0] = '{8'b10010100, 1'b1, 4'd3, 1'b0};  // H,L,L,H,L,H,L,L
    win_tab[1] = '{8'b00000000, 1'b1, 4'd0, 1'b0};  // all L, no gap
    win_tab[2] = '{8'b11111111, 1'b1, 4'd8, 1'b0};  // all H
    win_tab[3] = '{8'b01101101, 1'b1, 4'd5, 1'b0};
    win_tab[4] = '{8'b11111000, 1'b0, 4'd5, 1'b0};  // unaccepted
    win_tab[5] = '{8'b11000000, 1'b0, 4'd2, 1'b1};  // overwrite -> ovf
    filt[0] = 3'b111; filt[1] = 3'b011; filt[2] = 3'b010;
    filt[3] = 3'b001; filt[4] = 3'b100;

    // T1: reset with random phases
    reset = 1'b0; setupBias = 1'b1; code_rdy = 1'b0; ovf_clr = 1'b0;
    {PA, PB, PC} = 3'b000;
    for (int i = 0; i < 6; i++) begin
      {PA, PB, PC} = 3'($urandom_range(0, 7));
      cycle();
    end
    chk("rst_code", 32'(code_a), 32'd0);
    chk("rst_vld",  32'(vld_b),  32'd0);
    chk("rst_ovf",  32'(ovf_a),  32'd0);
    chk("rst_busy", 32'(busy_b), 32'd0);
    {PA, PB, PC} = 3'b110;
    reset = 1'b1;
    repeat (3) cycle();
    chk("rel_busy", 32'(busy_a), 32'd0);
    set_idle();
    cycle();

    // T2: all-H, dut_a drops 2 then completes on the 10th H edge
    setupBias = 1'b0; code_rdy = 1'b1;
    repeat (3) cycle();
    repeat (9) pulse(1'b1);
    drive_phase(1'b1);
    cycle();
    chk("allh_code", 32'(code_a), 32'd8);
    chk("allh_vld",  32'(vld_a),  32'd1);
    cycle();
    chk("allh_vld_drop", 32'(vld_a), 32'd0);
    cycle();
    set_idle();
    repeat (2) cycle();

    // Abort clears the partial window in dut_b before the table windows
    setupBias = 1'b1;
    repeat (2) cycle();
    chk("abort_busy_a", 32'(busy_a), 32'd0);
    chk("abort_busy_b", 32'(busy_b), 32'd0);
    chk("abort_code_a", 32'(code_a), 32'd8);
    setupBias = 1'b0;
    repeat (3) cycle();

    // T3/T4: table-driven windows on dut_b
    for (int i = 0; i < 6; i++) run_window(win_tab[i], i);
    ovf_clr = 1'b1;
    cycle();
    chk("ovf_clr_ovf",  32'(ovf_b),  32'd0);
    chk("ovf_clr_vld",  32'(vld_b),  32'd1);
    chk("ovf_clr_code", 32'(code_b), 32'd2);
    ovf_clr = 1'b0; code_rdy = 1'b1;
    cycle();
    chk("accept_vld", 32'(vld_b), 32'd0);

    // T5: abort after 5 events; the partial window is discarded
    repeat (5) pulse(1'b1);
    setupBias = 1'b1;
    cycle();
    chk("t5_busy", 32'(busy_b), 32'd0);
    chk("t5_code", 32'(code_b), 32'd2);
    chk("t5_vld",  32'(vld_b),  32'd0);
    cycle();
    setupBias = 1'b0;
    repeat (3) cycle();
    repeat (7) pulse(1'b1);
    drive_phase(1'b1);
    cycle();
    chk("t5_b_code", 32'(code_b), 32'd8);
    chk("t5_b_vld",  32'(vld_b),  32'd1);
    chk("t5_a_vld8", 32'(vld_a),  32'd0);
    repeat (2) cycle();
    set_idle();
    repeat (2) cycle();
    pulse(1'b1);
    drive_phase(1'b1);
    cycle();
    chk("t5_a_vld10", 32'(vld_a),  32'd1);
    chk("t5_a_code",  32'(code_a), 32'd8);
    repeat (2) cycle();
    set_idle();
    repeat (2) cycle();

    // T6: non-charge phases produce no events (dut_b holds 2 events here)
    for (int i = 0; i < 5; i++) begin
      {PA, PB, PC} = filt[i];
      repeat (2) cycle();
      set_idle();
      repeat (2) cycle();
    end
    repeat (5) pulse(1'b1);
    chk("filt_vld_pre", 32'(vld_b), 32'd0);
    drive_phase(1'b1);
    cycle();
    chk("filt_vld", 32'(vld_b), 32'd1);
    repeat (2) cycle();
    set_idle();
    repeat (2) cycle();
    // H directly followed by L: both edges count
    for (int p = 0; p < 4; p++) begin
      drive_phase(1'b1);
      repeat (2) cycle();
      drive_phase(1'b0);
      cycle();
      if (p == 3) begin
        chk("hl_code", 32'(code_b), 32'd4);
        chk("hl_vld",  32'(vld_b),  32'd1);
      end
      cycle();
      set_idle();
      repeat (2) cycle();
    end

    // Randomized phases, aborts, back-pressure and clears vs the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4)      {PA, PB, PC} = 3'b000;
      else if (r < 6) {PA, PB, PC} = 3'b110;
      else if (r < 8) {PA, PB, PC} = 3'b101;
      else if (r < 9) {PA, PB, PC} = 3'b111;
      else            {PA, PB, PC} = 3'($urandom_range(0, 7));
      setupBias = ($urandom_range(0, 59) == 0);
      code_rdy  = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 3)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
